onehot_capture_fifo: RTL and testbench
======================================

Name: onehot_capture_fifo

Overview:
- Downstream consumer of the 4-to-16 decoder stage.
- Accepts the 16 one-hot lines d0..d15 when a valid strobe is present.
- Checks that exactly one line is high and re-encodes the word to a 4-bit index with an error flag.
- Buffers results in a small first-word-fall-through FIFO with a valid/ready output handshake, and keeps a saturating error count for the bench and for later stages.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, 2..16).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- d0..d15  input  1 each  one-hot lines from the decoder stage (d0 = index 0).
- in_valid  input  1  d0..d15 hold a word to capture this cycle.
- in_ready  output  1  block can accept a word this cycle.
- out_code  output  4  encoded index of the FIFO head entry.
- out_err  output  1  error flag of the FIFO head entry.
- out_valid  output  1  FIFO head entry is valid.
- out_ready  input  1  consumer takes the head entry this cycle.
- err_count  output  CNT_W  number of accepted words that were flagged as errors (saturating).
- level  output  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset; it is sampled only on the rising edge of clk.
- Reset values: wr_ptr = 0, rd_ptr = 0, level = 0, err_count = 0, out_valid = 0, out_code = 0, out_err = 0, in_ready = 1 (from the first cycle after reset).
- Reset mid-operation: reset has priority over every push and pop in the same cycle. All buffered entries are discarded and no handshake completes on that edge.
- Encode rule (combinational on d0..d15):
  - Popcount == 1: code = index of the set line, err = 0.
  - Popcount == 0: code = 0, err = 1.
  - Popcount >= 2: code = lowest set index, err = 1.
- Push:
  - in_ready = (level != DEPTH), derived only from registered state.
  - A push occurs when in_valid && in_ready; {err, code} is written at wr_ptr and wr_ptr increments modulo DEPTH.
  - When full, in_valid is ignored: no write, and the word is not counted as an error.
- Pop:
  - out_valid = (level != 0).
  - out_code and out_err show the head entry (first-word-fall-through) and are forced to 0 when the FIFO is empty.
  - A pop occurs when out_valid && out_ready; rd_ptr increments modulo DEPTH.
- Latency: a word accepted at edge N is visible on out_code/out_valid in the cycle after edge N when the FIFO was empty. Data never bypasses combinationally from d* to out_*.
- Simultaneous push and pop:
  - Allowed whenever both handshakes are true; level is unchanged.
  - When full, in_ready = 0, so no push can happen that cycle even if a pop occurs.
  - When empty, only the push happens.
- Pointer wrap-around: pointers wrap modulo DEPTH; full and empty are distinguished by level, never by pointer equality alone.
- Error counter: increments by 1 on each accepted push with err = 1 and saturates at 2^CNT_W-1. Rejected words never increment it.
- Input stability: d0..d15 are don't-care when in_valid = 0 and cause no state change.

Test Plan:
- Reset, then d5 = 1 with in_valid for 1 cycle, out_ready = 1 -> next cycle out_valid = 1, out_code = 5, out_err = 0; following cycle out_valid = 0, level = 0, err_count = 0.
- Push d3 and d9 high together, then push all-zero, with out_ready = 0 -> head shows code 3, err 1; after one pop the head shows code 0, err 1; err_count = 2.
- out_ready = 0, push indices 1,2,3,4 then attempt 7 -> in_ready = 0 after the 4th push, level = 4, index 7 dropped; draining yields 1,2,3,4 in order.
- With level = 2, hold in_valid and out_ready high for 10 cycles pushing 0..9 -> level stays 2; output order is continuous with the pointers wrapping.
- Push 300 zero-hot words, draining continuously -> err_count stops at 255.
- Fill with 3 entries, assert reset together with in_valid and out_ready -> next cycle level = 0, out_valid = 0, err_count = 0, in_ready = 1.

Source files
------------

// File: rtl/onehot_capture_fifo.sv
// Captures one-hot decoder words, re-encodes them to {err, code} and buffers them
// in a first-word-fall-through FIFO with a saturating count of malformed words.
module onehot_capture_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       d0,
    input  logic                       d1,
    input  logic                       d2,
    input  logic                       d3,
    input  logic                       d4,
    input  logic                       d5,
    input  logic                       d6,
    input  logic                       d7,
    input  logic                       d8,
    input  logic                       d9,
    input  logic                       d10,
    input  logic                       d11,
    input  logic                       d12,
    input  logic                       d13,
    input  logic                       d14,
    input  logic                       d15,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [3:0]                 out_code,
    output logic                       out_err,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CNT_W-1:0]           err_count,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [15:0]      w_d;
    logic [4:0]       w_pop_cnt;
    logic [3:0]       w_low_idx;
    logic             w_enc_err;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;

    logic [4:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [CNT_W-1:0] r_err_count;

    assign w_d = {d15, d14, d13, d12, d11, d10, d9, d8, d7, d6, d5, d4, d3, d2, d1, d0};

    // Scanning downward lets the lowest set line win when several are high.
    always_comb begin
        w_pop_cnt = '0;
        w_low_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (w_d[i]) begin
                w_low_idx = 4'(i);
            end
            w_pop_cnt = w_pop_cnt + 5'(w_d[i]);
        end
        w_enc_err = (w_pop_cnt != 5'd1);
    end

    // Handshake: a transfer happens on a rising edge only when valid and ready are
    // both high; ready depends on registered occupancy, never on the valid input.
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = out_ready && !w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_err_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_enc_err, w_low_idx};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                if (w_enc_err && (r_err_count != {CNT_W{1'b1}})) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_code  = w_empty ? 4'd0 : r_mem[r_rd_ptr][3:0];
    assign out_err   = w_empty ? 1'b0 : r_mem[r_rd_ptr][4];
    assign err_count = r_err_count;
    assign level     = r_level;

endmodule

// File: tb/tb_onehot_capture_fifo.sv
// Directed bench for onehot_capture_fifo: inputs change and outputs are checked on
// the falling edge, so every check sees the state left by the preceding rising edge.
module tb_onehot_capture_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] d_vec = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  out_code;
    logic        out_err;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  err_count;
    logic [2:0]  level;

    int n_checks = 0;
    int n_pass = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    onehot_capture_fifo #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .d0(d_vec[0]), .d1(d_vec[1]), .d2(d_vec[2]), .d3(d_vec[3]),
        .d4(d_vec[4]), .d5(d_vec[5]), .d6(d_vec[6]), .d7(d_vec[7]),
        .d8(d_vec[8]), .d9(d_vec[9]), .d10(d_vec[10]), .d11(d_vec[11]),
        .d12(d_vec[12]), .d13(d_vec[13]), .d14(d_vec[14]), .d15(d_vec[15]),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_code(out_code), .out_err(out_err), .out_valid(out_valid),
        .out_ready(out_ready), .err_count(err_count), .level(level)
    );

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] w);
        d_vec = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        d_vec = $urandom_range(0, 65535);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (level !== 3'd0) $display("FAIL reset_level: got %0d expected 0", level); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b expected 0", out_valid); else n_pass++;
        n_checks++; if (out_code !== 4'd0 || out_err !== 1'b0) $display("FAIL reset_head: got code %0d err %0b expected 0/0", out_code, out_err); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL reset_err_count: got %0d expected 0", err_count); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b expected 1", in_ready); else n_pass++;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        push_word(16'h0001 << 5);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %0b expected 1", out_valid); else n_pass++;
        n_checks++; if (out_code !== 4'd5 || out_err !== 1'b0) $display("FAIL single_head: got code %0d err %0b expected 5/0", out_code, out_err); else n_pass++;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_drained_valid: got %0b expected 0", out_valid); else n_pass++;
        n_checks++; if (level !== 3'd0) $display("FAIL single_drained_level: got %0d expected 0", level); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL single_err_count: got %0d expected 0", err_count); else n_pass++;
    endtask

    task automatic test_errors();
        push_word((16'h0001 << 3) | (16'h0001 << 9));
        push_word(16'h0000);
        n_checks++; if (out_code !== 4'd3 || out_err !== 1'b1) $display("FAIL multi_hot_head: got code %0d err %0b expected 3/1", out_code, out_err); else n_pass++;
        n_checks++; if (level !== 3'd2) $display("FAIL errors_level: got %0d expected 2", level); else n_pass++;
        n_checks++; if (err_count !== 8'd2) $display("FAIL errors_count: got %0d expected 2", err_count); else n_pass++;
        pop_one();
        n_checks++; if (out_code !== 4'd0 || out_err !== 1'b1) $display("FAIL zero_hot_head: got code %0d err %0b expected 0/1", out_code, out_err); else n_pass++;
        pop_one();
        n_checks++; if (level !== 3'd0 || err_count !== 8'd2) $display("FAIL errors_drained: got level %0d count %0d expected 0/2", level, err_count); else n_pass++;
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) push_word(16'h0001 << i);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %0b expected 0", in_ready); else n_pass++;
        n_checks++; if (level !== 3'd4) $display("FAIL full_level: got %0d expected 4", level); else n_pass++;
        push_word(16'h0000);
        push_word(16'h0001 << 7);
        n_checks++; if (level !== 3'd4) $display("FAIL full_drop_level: got %0d expected 4", level); else n_pass++;
        n_checks++; if (err_count !== 8'd2) $display("FAIL full_drop_err_count: got %0d expected 2", err_count); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_code !== 4'(i) || out_err !== 1'b0)
                $display("FAIL full_drain_%0d: got valid %0b code %0d err %0b expected 1/%0d/0", i, out_valid, out_code, out_err, i);
            else n_pass++;
            pop_one();
        end
        n_checks++; if (out_valid !== 1'b0 || level !== 3'd0) $display("FAIL full_drain_empty: got valid %0b level %0d expected 0/0", out_valid, level); else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        push_word(16'h0001 << 10); exp_q.push_back(4'd10);
        push_word(16'h0001 << 11); exp_q.push_back(4'd11);
        for (int k = 0; k < 10; k++) begin
            d_vec = 16'h0001 << k;
            in_valid = 1'b1;
            out_ready = 1'b1;
            #1;
            n_checks++; if (out_code !== exp_q[0] || in_ready !== 1'b1) $display("FAIL b2b_head_%0d: got code %0d ready %0b expected %0d/1", k, out_code, in_ready, exp_q[0]); else n_pass++;
            exp_q.push_back(4'(k));
            @(negedge clk);
            void'(exp_q.pop_front());
            n_checks++; if (level !== 3'd2) $display("FAIL b2b_level_%0d: got %0d expected 2", k, level); else n_pass++;
        end
        in_valid = 1'b0;
        while (exp_q.size() > 0) begin
            n_checks++; if (out_valid !== 1'b1 || out_code !== exp_q[0]) $display("FAIL b2b_drain: got valid %0b code %0d expected 1/%0d", out_valid, out_code, exp_q[0]); else n_pass++;
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        out_ready = 1'b0;
        n_checks++; if (level !== 3'd0) $display("FAIL b2b_final_level: got %0d expected 0", level); else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1;
        d_vec = 16'h0000;
        in_valid = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 100) begin
                n_checks++; if (err_count !== 8'd100) $display("FAIL sat_mid: got %0d expected 100", err_count); else n_pass++;
            end
            if (i == 254) begin
                n_checks++; if (err_count !== 8'd254) $display("FAIL sat_254: got %0d expected 254", err_count); else n_pass++;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++; if (err_count !== 8'd255) $display("FAIL sat_final: got %0d expected 255", err_count); else n_pass++;
        n_checks++; if (level !== 3'd0) $display("FAIL sat_level: got %0d expected 0", level); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_word(16'h0001 << 1);
        push_word(16'h0000);
        push_word(16'h0001 << 2);
        n_checks++; if (level !== 3'd3 || err_count !== 8'd1) $display("FAIL pre_reset: got level %0d count %0d expected 3/1", level, err_count); else n_pass++;
        reset = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        d_vec = 16'h0000;
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (level !== 3'd0) $display("FAIL mid_reset_level: got %0d expected 0", level); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_reset_valid: got %0b expected 0", out_valid); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL mid_reset_err_count: got %0d expected 0", err_count); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_reset_in_ready: got %0b expected 1", in_ready); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_errors();
        test_full();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
